pivot_row_fetch: RTL and testbench
==================================

PIVOT_ROW_FETCH -- requirements
Module: pivot_row_fetch

Interface
REQ-001 SHALL have parameter DATAW, default 32: tableau element width (IEEE-754 single).
REQ-002 SHALL have parameter ADDRW, default 32: tableau BRAM word-address width.
REQ-003 SHALL have parameter RD_LAT, default 2: BRAM read latency in cycles, from ren to rdata valid.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: output buffer depth; must be >= RD_LAT+1.
REQ-005 SHALL have these ports, one clock domain, synchronous active-high reset:
 clk  in  1  rising-edge clock
 reset  in  1  synchronous, active-high
 start  in  1  single-cycle request to fetch one pivot row
 pivot_row_idx  in  16  tableau row to fetch
 pivot_col_idx  in  16  column holding the pivot element
 num_cols  in  16  tableau row length
 ren  out  1  BRAM read enable
 raddr  out  ADDRW  BRAM word address
 rdata  in  DATAW  BRAM read data
 factor_out  out  DATAW  latched pivot element
 factor_valid  out  1  factor_out is valid for the current row
 M_AXIS_PIVOTROW_TDATA  out  DATAW  row element
 M_AXIS_PIVOTROW_TVALID  out  1  beat valid
 M_AXIS_PIVOTROW_TREADY  in  1  downstream ready
 M_AXIS_PIVOTROW_TLAST  out  1  marks element num_cols-1
 busy  out  1  high in any state other than IDLE
 done  out  1  one-cycle pulse when the row is finished or rejected
 error  out  1  one-cycle pulse, coincident with done, on a rejected request

Function
REQ-006 SHALL implement the states IDLE, FACTOR, STREAM.
REQ-007 In IDLE, start SHALL latch all three indices, compute base = pivot_row_idx*num_cols (ADDRW bits, zero-extended), clear factor_valid, and go to FACTOR.
REQ-008 If num_cols==0 or pivot_col_idx>=num_cols at start, the block SHALL stay in IDLE, issue no read, and pulse done and error on the next cycle.
REQ-009 In FACTOR, the block SHALL issue exactly one read at base+pivot_col_idx.
- The data SHALL be captured into factor_out exactly RD_LAT cycles after that read.
- factor_valid SHALL be set in the same cycle, and the state SHALL change to STREAM on the following edge.
REQ-010 factor_out and factor_valid SHALL hold until the next accepted start or reset; a zero factor SHALL be passed through unchanged, because the divide stage flags it.
REQ-011 In STREAM, the block SHALL issue reads at base+0 .. base+num_cols-1 in order, at most one per cycle.
- A read SHALL issue only when (reads in flight + FIFO occupancy) < FIFO_DEPTH.
REQ-012 Read data SHALL be pushed into the FIFO RD_LAT cycles after issue, using a valid shift register of length RD_LAT.
REQ-013 The FIFO head SHALL drive TDATA; TVALID = FIFO not empty; a pop SHALL occur on TVALID&&TREADY.
REQ-014 TLAST SHALL be high only on the beat carrying column num_cols-1 (a tag bit stored per FIFO entry).
REQ-015 With TREADY held high, the block SHALL sustain one beat per cycle.
- The first beat SHALL appear RD_LAT+1 cycles after entering STREAM.
REQ-016 TDATA/TLAST SHALL remain stable while TVALID&&!TREADY; TVALID SHALL never drop without a handshake.
REQ-017 A simultaneous FIFO push and pop SHALL leave occupancy unchanged; the FIFO SHALL never overflow (guaranteed by REQ-011).
REQ-018 On the TLAST handshake, the block SHALL return to IDLE and pulse done in the same cycle.
REQ-019 start SHALL be ignored while busy.
REQ-020 ren SHALL be asserted only in the cycle of a read issue; raddr SHALL be don't-care otherwise.

Reset
REQ-021 While reset is high, all outputs SHALL take their reset values: ren=0, raddr=0, factor_out=0, factor_valid=0, TVALID=0, TDATA=0, TLAST=0, busy=0, done=0, error=0.
REQ-022 Reset SHALL return the state machine to IDLE.
REQ-023 Reset SHALL empty the FIFO, clear the in-flight shift register and the read counter.
- Data returned by BRAM after a mid-row reset SHALL be discarded.

Verification
REQ-024 The bench SHALL cover nominal fetch: BRAM row 2 of a 4-column tableau = {4.0, 5.5, 0.5, -0.5}; start with row=2, col=1, num_cols=4, TREADY=1.
- Expect reads at addresses 9, then 8, 9, 10, 11.
- Expect factor_out=0x40B00000 and factor_valid=1.
- Expect beats 0x40800000, 0x40B00000, 0x3F000000, 0xBF000000 on consecutive cycles, TLAST on the 4th, done on the same cycle.
REQ-025 The bench SHALL cover backpressure: the same row with TREADY toggled 1,0,0,1,...
- Expect the 4 beats in order, none lost or duplicated.
- Expect TDATA stable while stalled, and FIFO occupancy never above 4.
REQ-026 The bench SHALL cover rejection: start with num_cols=4, col=4.
- Expect no ren, done=1 and error=1 one cycle later, and factor_valid=0.
REQ-027 The bench SHALL cover reset mid-row: assert reset after 2 beats, then release.
- Expect TVALID=0 and busy=0.
- Expect no stray beat after release.
- A new start SHALL stream a full, correct row.
REQ-028 The bench SHALL cover a single-column row: num_cols=1, col=0, data 0.0.
- Expect factor_out=0 and factor_valid=1.
- Expect one beat with TLAST=1, and done.
REQ-029 The bench SHALL cover start while busy: a second start mid-STREAM.
- Expect it ignored, and the current row to complete unchanged.

Source files
------------

// File: rtl/pivot_row_fetch.sv
// Pivot row fetch: reads the pivot element of one tableau row, then streams the
// whole row over AXI-Stream through a small FIFO with read-issue credit control.
module pivot_row_fetch #(
    parameter int unsigned DATAW      = 32,
    parameter int unsigned ADDRW      = 32,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [15:0]      pivot_row_idx,
    input  logic [15:0]      pivot_col_idx,
    input  logic [15:0]      num_cols,
    output logic             ren,
    output logic [ADDRW-1:0] raddr,
    input  logic [DATAW-1:0] rdata,
    output logic [DATAW-1:0] factor_out,
    output logic             factor_valid,
    output logic [DATAW-1:0] M_AXIS_PIVOTROW_TDATA,
    output logic             M_AXIS_PIVOTROW_TVALID,
    input  logic             M_AXIS_PIVOTROW_TREADY,
    output logic             M_AXIS_PIVOTROW_TLAST,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StFactor, StStream} state_e;

    state_e            state_q, state_d;
    logic [15:0]       col_q, ncols_q, rd_cnt_q;
    logic [ADDRW-1:0]  base_q;
    logic              issued_q, rej_q;
    logic [RD_LAT-1:0] vld_sr_q, last_sr_q;
    logic [DATAW-1:0]  factor_q;
    logic              factor_valid_q;

    logic [DATAW-1:0]      fifo_data_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fifo_last_q;
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         cnt_q;

    logic        bad_req, accept, reject;
    logic        fac_issue, str_issue, issue, issue_last;
    logic        arrive, fac_cap, push, pop, tvalid_int, last_pop;
    logic [31:0] inflight;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RD_LAT); i++) begin
            inflight = inflight + 32'(vld_sr_q[i]);
        end
    end

    assign bad_req = (num_cols == 16'd0) || (pivot_col_idx >= num_cols);
    assign accept  = (state_q == StIdle) && start && !bad_req;
    assign reject  = (state_q == StIdle) && start && bad_req;

    assign fac_issue = (state_q == StFactor) && !issued_q;
    // Credit check: every outstanding read must already own a FIFO slot.
    assign str_issue = (state_q == StStream) && (rd_cnt_q < ncols_q) &&
                       ((inflight + 32'(cnt_q)) < FIFO_DEPTH);
    assign issue      = fac_issue || str_issue;
    assign issue_last = str_issue && (rd_cnt_q == ncols_q - 16'd1);

    assign arrive     = vld_sr_q[RD_LAT-1];
    assign fac_cap    = arrive && (state_q == StFactor);
    assign push       = arrive && (state_q == StStream);
    assign tvalid_int = (cnt_q != '0);
    assign pop        = tvalid_int && M_AXIS_PIVOTROW_TREADY;
    assign last_pop   = pop && fifo_last_q[rd_ptr_q];

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept)   state_d = StFactor;
            StFactor: if (fac_cap)  state_d = StStream;
            StStream: if (last_pop) state_d = StIdle;
            default:                state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            col_q          <= '0;
            ncols_q        <= '0;
            base_q         <= '0;
            rd_cnt_q       <= '0;
            issued_q       <= 1'b0;
            rej_q          <= 1'b0;
            vld_sr_q       <= '0;
            last_sr_q      <= '0;
            factor_q       <= '0;
            factor_valid_q <= 1'b0;
            fifo_last_q    <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
        end else begin
            state_q <= state_d;
            rej_q   <= reject;
            if (accept) begin
                col_q          <= pivot_col_idx;
                ncols_q        <= num_cols;
                base_q         <= ADDRW'(32'(pivot_row_idx) * 32'(num_cols));
                rd_cnt_q       <= '0;
                issued_q       <= 1'b0;
                factor_valid_q <= 1'b0;
            end
            if (fac_issue) issued_q <= 1'b1;
            if (str_issue) rd_cnt_q <= rd_cnt_q + 16'd1;
            if (fac_cap) begin
                factor_q       <= rdata;
                factor_valid_q <= 1'b1;
            end
            vld_sr_q[0]  <= issue;
            last_sr_q[0] <= issue_last;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld_sr_q[i]  <= vld_sr_q[i-1];
                last_sr_q[i] <= last_sr_q[i-1];
            end
            if (push) begin
                fifo_last_q[wr_ptr_q] <= last_sr_q[RD_LAT-1];
                wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) cnt_q <= cnt_q + 1'b1;
            else if (pop && !push) cnt_q <= cnt_q - 1'b1;
        end
    end

    // Payload needs no reset: TDATA is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) fifo_data_q[wr_ptr_q] <= rdata;
    end

    always_comb begin
        ren   = issue && !reset;
        raddr = '0;
        if (ren) raddr = fac_issue ? base_q + ADDRW'(col_q) : base_q + ADDRW'(rd_cnt_q);
        M_AXIS_PIVOTROW_TVALID = tvalid_int && !reset;
        M_AXIS_PIVOTROW_TDATA  = M_AXIS_PIVOTROW_TVALID ? fifo_data_q[rd_ptr_q] : '0;
        M_AXIS_PIVOTROW_TLAST  = M_AXIS_PIVOTROW_TVALID && fifo_last_q[rd_ptr_q];
        factor_out   = reset ? '0 : factor_q;
        factor_valid = factor_valid_q && !reset;
        busy         = (state_q != StIdle) && !reset;
        done         = !reset && (rej_q || last_pop);
        error        = !reset && rej_q;
    end

endmodule

// File: tb/tb_pivot_row_fetch.sv
// Randomized scoreboard bench for pivot_row_fetch: a row-level model queues the
// expected read addresses and beats; a negedge monitor checks them as they appear.
module tb_pivot_row_fetch;

    localparam int unsigned DATAW      = 32;
    localparam int unsigned ADDRW      = 32;
    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned FIFO_DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [15:0]      prow = '0, pcol = '0, ncols = '0;
    logic             ren;
    logic [ADDRW-1:0] raddr;
    logic [DATAW-1:0] rdata;
    logic [DATAW-1:0] factor_out;
    logic             factor_valid;
    logic [DATAW-1:0] tdata;
    logic             tvalid, tlast, busy, done, error;
    logic             tready = 1'b1;

    always #5 clk = ~clk;

    pivot_row_fetch #(
        .DATAW(DATAW), .ADDRW(ADDRW), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .pivot_row_idx(prow), .pivot_col_idx(pcol), .num_cols(ncols),
        .ren(ren), .raddr(raddr), .rdata(rdata),
        .factor_out(factor_out), .factor_valid(factor_valid),
        .M_AXIS_PIVOTROW_TDATA(tdata), .M_AXIS_PIVOTROW_TVALID(tvalid),
        .M_AXIS_PIVOTROW_TREADY(tready), .M_AXIS_PIVOTROW_TLAST(tlast),
        .busy(busy), .done(done), .error(error)
    );

    // BRAM model with RD_LAT-cycle read latency; not reset, so stale data keeps coming.
    logic [31:0] mem [0:1023];
    logic [31:0] bram_pipe [0:RD_LAT-1];
    always @(posedge clk) begin
        bram_pipe[0] <= ren ? mem[raddr[9:0]] : 32'hDEAD_BEEF;
        for (int i = 1; i < int'(RD_LAT); i++) bram_pipe[i] <= bram_pipe[i-1];
    end
    assign rdata = bram_pipe[RD_LAT-1];

    int          total = 0, bad = 0, cyc = 0;
    int          beats_seen = 0, first_cyc = 0, last_cyc = 0, outstanding = 0;
    int          rmode = 0, phase = 0;
    logic [31:0] exp_addr [$];
    logic [32:0] exp_beats [$];
    logic [31:0] exp_factor = '0;
    logic [32:0] e;
    logic        prev_stall = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // TREADY: 0 = always high, 1 = repeating 1,0,0, other = random.
    always @(posedge clk) begin
        #1;
        phase = (phase == 2) ? 0 : phase + 1;
        case (rmode)
            0:       tready = 1'b1;
            1:       tready = (phase == 0);
            default: tready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (ren) begin
                if (exp_addr.size() == 0) chk("ren with no read expected", ren, 0);
                else chk("raddr", raddr, exp_addr.pop_front());
                if (factor_valid) outstanding++;
            end
            if (prev_stall) begin
                chk("tvalid held while stalled", tvalid, 1);
                chk("tdata stable while stalled", tdata, prev_data);
                chk("tlast stable while stalled", tlast, prev_last);
            end
            if (tvalid && tready) begin
                outstanding--;
                if (exp_beats.size() == 0) begin
                    chk("stray beat", tvalid, 0);
                end else begin
                    e = exp_beats.pop_front();
                    chk("beat data", tdata, e[31:0]);
                    chk("beat last", tlast, e[32]);
                    chk("done with last beat", done, e[32]);
                end
                if (beats_seen == 0) first_cyc = cyc;
                last_cyc = cyc;
                beats_seen++;
            end
            if (ren && factor_valid) chk("reads+fifo bound", outstanding <= int'(FIFO_DEPTH), 1);
            prev_stall = tvalid && !tready;
            prev_data  = tdata;
            prev_last  = tlast;
        end
    end

    // Row-level model: pivot read, then columns 0..nc-1, TLAST on the final one.
    task automatic issue_row(input int row, input int col, input int nc);
        int base = row * nc;
        exp_addr.push_back(32'(base + col));
        for (int i = 0; i < nc; i++) begin
            exp_addr.push_back(32'(base + i));
            exp_beats.push_back({(i == nc - 1), mem[base + i]});
        end
        exp_factor = mem[base + col];
        beats_seen = 0;
        @(posedge clk); #1;
        prow = 16'(row); pcol = 16'(col); ncols = 16'(nc); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic finish_row(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 400);
        chk({tag, " done seen"}, done, 1);
        @(negedge clk);
        chk({tag, " beats left"}, exp_beats.size(), 0);
        chk({tag, " reads left"}, exp_addr.size(), 0);
        chk({tag, " factor_out"}, factor_out, exp_factor);
        chk({tag, " factor_valid"}, factor_valid, 1);
        chk({tag, " idle after done"}, busy, 0);
    endtask

    task automatic wait_beats(input int k);
        int n = 0;
        while (beats_seen < k && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("beats before event", beats_seen >= k, 1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[8] = 32'h4080_0000; mem[9] = 32'h40B0_0000;
        mem[10] = 32'h3F00_0000; mem[11] = 32'hBF00_0000;
        mem[20] = 32'h0000_0000;

        repeat (3) @(negedge clk);
        chk("reset ren", ren, 0);
        chk("reset raddr", raddr, 0);
        chk("reset tvalid", tvalid, 0);
        chk("reset tdata", tdata, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset factor", {factor_valid, factor_out}, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Rejected request: column index out of range.
        @(posedge clk); #1;
        prow = 16'd1; pcol = 16'd4; ncols = 16'd4; start = 1'b1;
        @(negedge clk);
        chk("reject done early", done, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("reject done", done, 1);
        chk("reject error", error, 1);
        chk("reject factor_valid", factor_valid, 0);
        chk("reject busy", busy, 0);
        @(negedge clk);
        chk("reject pulse width", {done, error}, 0);

        rmode = 0;
        issue_row(2, 1, 4);
        finish_row("nominal");
        chk("nominal back-to-back beats", last_cyc - first_cyc, 3);

        rmode = 1;
        issue_row(2, 1, 4);
        finish_row("backpressure");

        // Reset in the middle of a row.
        issue_row(5, 3, 8);
        wait_beats(2);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_addr.delete();
        exp_beats.delete();
        outstanding = 0;
        @(negedge clk);
        chk("midreset tvalid", tvalid, 0);
        chk("midreset busy", busy, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("post-reset idle", busy, 0);
        issue_row(5, 3, 8);
        finish_row("after reset");

        rmode = 0;
        issue_row(20, 0, 1);
        finish_row("single column");
        chk("single column beat count", beats_seen, 1);

        // Second start while streaming must be ignored.
        rmode = 1;
        issue_row(3, 2, 6);
        wait_beats(1);
        @(posedge clk); #1;
        prow = 16'd1; pcol = 16'd0; ncols = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        finish_row("start while busy");
        repeat (10) @(negedge clk);
        chk("start while busy beat count", beats_seen, 6);

        rmode = 2;
        for (int k = 0; k < 12; k++) begin
            int nc, row, col;
            nc  = int'($urandom_range(1, 8));
            row = int'($urandom_range(0, 15));
            col = int'($urandom_range(0, nc - 1));
            issue_row(row, col, nc);
            finish_row("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
